mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64: data and address width of the bus.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13: request and response tag width.
REQ-003 SHALL have parameter NUM_LINES, default 16: backing-store lines of 512 bits each.
REQ-004 SHALL have parameter READ_LATENCY, default 4: cycles from request ack to first read beat; legal range 1..15.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port bus_reqcyc, input, 1 bit: initiator presents a request word (address, or write data).
REQ-008 SHALL have port bus_reqack, output, 1 bit: responder accepted the current request word.
REQ-009 SHALL have port bus_req, input, BUS_DATA_WIDTH bits: address in a request phase, data in a write-data phase.
REQ-010 SHALL have port bus_reqtag, input, BUS_TAG_WIDTH bits: request tag; bit 12 = 0 means write, 1 means read.
REQ-011 SHALL have port bus_respcyc, output, 1 bit: read response beat valid.
REQ-012 SHALL have port bus_respack, input, 1 bit: initiator consumed the current beat.
REQ-013 SHALL have port bus_resp, output, BUS_DATA_WIDTH bits: read beat data.
REQ-014 SHALL have port bus_resptag, output, BUS_TAG_WIDTH bits: tag of the request being answered.

Function
REQ-015 SHALL hold NUM_LINES x 512-bit storage; line index = address bits [6+log2(NUM_LINES)-1:6]; bits [5:0] and higher address bits ignored (aliasing permitted).
REQ-016 SHALL number beats 0..7; beat i is line bits [64*i+63:64*i], with a 3-bit beat counter.
REQ-017 SHALL implement states IDLE, ACKREQ, WDATA, WACK, RDLAT, RESP.
REQ-018 IDLE: on bus_reqcyc=1, SHALL capture bus_req as address and bus_reqtag as tag, then go to ACKREQ; otherwise stay in IDLE.
REQ-019 ACKREQ: SHALL drive bus_reqack=1 for exactly one cycle, clear the beat counter, and go to WDATA if tag bit 12=0, else to RDLAT with the latency counter loaded with READ_LATENCY-1.
REQ-020 WDATA: on bus_reqcyc=1, SHALL write bus_req into the current beat of the addressed line and go to WACK; otherwise wait.
REQ-021 WACK: SHALL drive bus_reqack=1 for one cycle, then go to IDLE if beat=7 (beat counter wraps to 0), else increment beat and go to WDATA.
REQ-022 RDLAT: SHALL decrement the latency counter each cycle and go to RESP when it is 0; first-beat latency after the ACKREQ cycle = READ_LATENCY cycles.
REQ-023 RESP: SHALL drive bus_respcyc=1, bus_resp=current beat and bus_resptag=captured tag, holding them stable until bus_respack=1 is sampled.
REQ-024 In RESP, when bus_respack=1 is sampled, SHALL advance to the next beat in the next cycle; after beat 7 is acked, SHALL go to IDLE with bus_respcyc=0.
REQ-025 SHALL drive bus_reqack=0 outside ACKREQ and WACK; SHALL drive bus_respcyc, bus_resp and bus_resptag to 0 outside RESP.
REQ-026 bus_reqcyc while in RESP or RDLAT SHALL be ignored (no ack) and not captured; the initiator holds it until IDLE.
REQ-027 A read of a line SHALL return the most recent completed write to it; a partially written line (reset mid-write) keeps the beats already written.
REQ-028 bus_respack outside RESP SHALL have no effect.

Reset
REQ-029 When reset asserts, SHALL immediately enter IDLE (asynchronously), with all outputs 0 and the beat and latency counters, captured address and captured tag at 0.
REQ-030 Reset SHALL clear all storage to 0; a transfer in progress is abandoned with no further acks or beats.

Verification
REQ-031 Write of line 3 (addr 0xC0, tag 0x0005), data beats 0x11..0x88 -> exactly 9 one-cycle reqack pulses (1 request + 8 data), then return to IDLE.
REQ-032 Read of addr 0xC0 with tag 0x1005 after REQ-031 -> first respcyc 4 cycles after the ack; beats 0x11..0x88 in order; resptag=0x1005 on every beat.
REQ-033 During a read, withhold respack for 5 cycles on beat 2 -> bus_resp is held at beat-2 data and respcyc stays 1; no beat is skipped or repeated.
REQ-034 Read of addr 0x4C0 (aliases line 3, NUM_LINES=16) -> returns the same data as REQ-032; read of a never-written line -> 8 zero beats.
REQ-035 Assert reset during beat 4 of a write, then read the line -> reset forces outputs to 0 at once; the read returns all zeros (storage cleared).
REQ-036 reqcyc held high during RESP of a prior read -> no reqack until the prior read finishes; the request is then accepted from IDLE.

Source files
------------

// File: rtl/mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Bus-side memory responder. Accepts a tagged request word,
//             then either absorbs eight write-data words into one 512-bit
//             line or streams that line back as eight read beats after a
//             fixed latency. Lines are NUM_LINES deep; NUM_LINES is a power
//             of two and at least 2.
//  Revision : 1.0  initial release
// ============================================================================
module mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int NUM_LINES      = 16,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    output logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    // Line index width; address bits [5:0] select a byte inside the line
    localparam int         c_LINE_W   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int         c_RD_BIT   = 12;
    localparam logic [3:0] c_LAT_INIT = 4'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACKREQ = 3'd1,
        S_WDATA  = 3'd2,
        S_WACK   = 3'd3,
        S_RDLAT  = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t                    state_q, state_d;
    logic [c_LINE_W-1:0]       line_q, line_d;
    logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [2:0]                beat_q, beat_d;
    logic [3:0]                lat_q, lat_d;
    logic                      wr_en;

    // Backing store: one entry per 64-bit beat of each line
    logic [BUS_DATA_WIDTH-1:0] mem_q [NUM_LINES][8];

    // Control registers; reset drops straight back to IDLE without a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            tag_q   <= '0;
            beat_q  <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            tag_q   <= tag_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
        end
    end

    // Storage: cleared by reset, written one beat per accepted data word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < NUM_LINES; l++) begin
                for (int b = 0; b < 8; b++) begin
                    mem_q[l][b] <= '0;
                end
            end
        end else if (wr_en) begin
            mem_q[line_q][beat_q] <= bus_req;
        end
    end

    // Next-state and Moore outputs; everything idles at zero by default
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        tag_d       = tag_q;
        beat_d      = beat_q;
        lat_d       = lat_q;
        wr_en       = 1'b0;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        bus_resptag = '0;

        case (state_q)
            S_IDLE: begin
                if (bus_reqcyc) begin
                    line_d  = bus_req[6 +: c_LINE_W];
                    tag_d   = bus_reqtag;
                    state_d = S_ACKREQ;
                end
            end

            S_ACKREQ: begin
                bus_reqack = 1'b1;
                beat_d     = '0;
                if (!tag_q[c_RD_BIT]) begin
                    state_d = S_WDATA;
                end else begin
                    lat_d = c_LAT_INIT;
                    // A latency of one means the first beat follows the ack directly
                    state_d = (READ_LATENCY <= 1) ? S_RESP : S_RDLAT;
                end
            end

            S_WDATA: begin
                if (bus_reqcyc) begin
                    wr_en   = 1'b1;
                    state_d = S_WACK;
                end
            end

            S_WACK: begin
                bus_reqack = 1'b1;
                beat_d     = beat_q + 3'd1;
                state_d    = (beat_q == 3'd7) ? S_IDLE : S_WDATA;
            end

            S_RDLAT: begin
                // Counter starts at latency-1 and RESP begins as it reaches zero,
                // so the first beat lands READ_LATENCY cycles after the ack cycle
                if (lat_q != 4'd0) begin
                    lat_d = lat_q - 4'd1;
                end
                if (lat_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                bus_respcyc = 1'b1;
                bus_resp    = mem_q[line_q][beat_q];
                bus_resptag = tag_q;
                if (bus_respack) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Self-checking bench for mem_responder with a line-level
//             reference model and randomized traffic and stalls.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_responder;

    localparam int c_DW = 64;
    localparam int c_TW = 13;
    localparam int c_NL = 16;
    localparam int c_RL = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            bus_reqcyc;
    logic            bus_reqack;
    logic [c_DW-1:0] bus_req;
    logic [c_TW-1:0] bus_reqtag;
    logic            bus_respcyc;
    logic            bus_respack;
    logic [c_DW-1:0] bus_resp;
    logic [c_TW-1:0] bus_resptag;

    always #5 clk = ~clk;

    mem_responder #(
        .BUS_DATA_WIDTH (c_DW),
        .BUS_TAG_WIDTH  (c_TW),
        .NUM_LINES      (c_NL),
        .READ_LATENCY   (c_RL)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_reqack  (bus_reqack),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_respcyc (bus_respcyc),
        .bus_respack (bus_respack),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ack_hi  = 0;
    logic [63:0] model_mem [c_NL][8];
    logic [63:0] wdata [8];

    // Count every cycle in which reqack is high
    always @(negedge clk) begin
        if (bus_reqack === 1'b1) ack_hi++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int line_of(input logic [63:0] addr);
        return int'((addr >> 6) % c_NL);
    endfunction

    task automatic model_clear();
        for (int l = 0; l < c_NL; l++)
            for (int b = 0; b < 8; b++)
                model_mem[l][b] = 64'h0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_reqack"},  64'(bus_reqack),  64'h0);
        check({tag, "_respcyc"}, 64'(bus_respcyc), 64'h0);
        check({tag, "_resp"},    bus_resp,         64'h0);
        check({tag, "_resptag"}, 64'(bus_resptag), 64'h0);
    endtask

    // Wait at negedges until reqack is seen; a timeout is reported as a failure
    task automatic wait_ack(input string what);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_reqack !== 1'b1 && n < 50);
        if (bus_reqack !== 1'b1) check({what, "_ack_timeout"}, 64'(bus_reqack), 64'h1);
    endtask

    // Present a request word until acked; returns just after the following edge
    task automatic send_req(input logic [63:0] addr, input logic [12:0] tag);
        bus_reqcyc  = 1'b1;
        bus_req     = addr;
        bus_reqtag  = tag;
        bus_respack = 1'($urandom_range(0, 1));
        wait_ack("req");
        @(posedge clk);
        #1;
    endtask

    // Eight-beat write of wdata[]; abort_beat < 8 resets the DUT after that beat's ack
    task automatic do_write(input logic [63:0] addr, input logic [11:0] tag12, input int abort_beat);
        int a0 = ack_hi;
        int ln = line_of(addr);
        send_req(addr, {1'b0, tag12});
        for (int b = 0; b < 8; b++) begin
            bus_reqcyc  = 1'b1;
            bus_req     = wdata[b];
            bus_respack = 1'($urandom_range(0, 1));
            wait_ack("wdata");
            model_mem[ln][b] = wdata[b];
            if (b == abort_beat) begin
                #2 reset = 1'b1;
                #1 check_idle_outputs("rst_midwrite");
                model_clear();
                bus_reqcyc = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        bus_reqcyc = 1'b0;
        repeat (3) @(negedge clk);
        check("write_ack_cycles", 64'(ack_hi - a0), 64'd9);
        check("write_idle_reqack", 64'(bus_reqack), 64'h0);
    endtask

    // Consume the eight read beats of a request already acked.
    // stall_beat: beat on which respack is withheld for 5 cycles.
    // inject: present a new request during RESP and verify it is not acked.
    task automatic read_body(input int ln, input logic [12:0] tag, input int stall_beat,
                             input bit inject, input logic [63:0] inj_addr,
                             input logic [12:0] inj_tag);
        int n     = 0;
        int beat  = 0;
        int stall = 0;
        int cyc   = 0;
        bus_reqcyc = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_respcyc !== 1'b1 && n < 20);
        check("rd_latency", 64'(n), 64'(c_RL));
        while (beat < 8 && cyc < 200) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (inject) check("busy_no_reqack", 64'(bus_reqack), 64'h0);
            check("respcyc", 64'(bus_respcyc), 64'h1);
            check($sformatf("resp_beat%0d", beat), bus_resp, model_mem[ln][beat]);
            check("resptag", 64'(bus_resptag), 64'(tag));
            if (inject && beat == 0) begin
                bus_reqcyc = 1'b1;
                bus_req    = inj_addr;
                bus_reqtag = inj_tag;
            end
            if (beat == stall_beat && stall < 5) begin
                bus_respack = 1'b0;
                stall++;
            end else if ($urandom_range(0, 3) == 0) begin
                bus_respack = 1'b0;
            end else begin
                bus_respack = 1'b1;
                beat++;
            end
        end
        @(negedge clk);
        bus_respack = 1'($urandom_range(0, 1));
        check("rd_end_respcyc", 64'(bus_respcyc), 64'h0);
        check("rd_end_resp",    bus_resp,         64'h0);
        check("rd_end_resptag", 64'(bus_resptag), 64'h0);
        if (inject) check("rd_end_no_reqack", 64'(bus_reqack), 64'h0);
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [11:0] tag12, input int stall_beat);
        send_req(addr, {1'b1, tag12});
        read_body(line_of(addr), {1'b1, tag12}, stall_beat, 1'b0, 64'h0, 13'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, simulation still running");
        $fatal(1);
    end

    initial begin
        logic [63:0] a;
        reset       = 1'b1;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        model_clear();

        repeat (2) @(negedge clk);
        check_idle_outputs("in_reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset");

        // Known-pattern write to line 3, then read back with a stall on beat 2
        for (int b = 0; b < 8; b++) wdata[b] = 64'(b + 1) * 64'h11;
        do_write(64'h0C0, 12'h005, 8);
        do_read(64'h0C0, 12'h005, 2);
        // Alias of line 3 and a never-written line
        do_read(64'h4C0, 12'h005, 8);
        do_read(64'h140, 12'h0A7, 8);

        // Randomized traffic with random upper address bits
        for (int i = 0; i < 8; i++) begin
            a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < 8; b++) wdata[b] = {$urandom, $urandom};
                do_write(a, 12'($urandom), 8);
            end else begin
                do_read(a, 12'($urandom), int'($urandom_range(0, 9)));
            end
        end

        // Request held during RESP of an earlier read is taken only afterwards
        send_req(64'h0C0, 13'h1005);
        read_body(3, 13'h1005, 8, 1'b1, 64'h140, 13'h1123);
        wait_ack("held_req");
        @(posedge clk);
        #1;
        read_body(5, 13'h1123, 8, 1'b0, 64'h0, 13'h0);

        // Reset during beat 4 of a write clears all storage
        for (int b = 0; b < 8; b++) wdata[b] = {$urandom, $urandom} | 64'h1;
        do_write(64'h1C0, 12'h031, 8);
        do_read(64'h1C0, 12'h031, 8);
        do_write(64'h1C0, 12'h032, 4);
        @(negedge clk);
        check_idle_outputs("post_reset_idle");
        do_read(64'h1C0, 12'h033, 8);
        do_read(64'h0C0, 12'h034, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
